// File: rtl/ha_pkg.sv
// Shared types for the half-adder result scoreboard: result layout, collector
// state encoding and the reference {carry, sum} function.
package ha_pkg;

  typedef struct packed {
    logic carry;
    logic sum;
  } ha_result_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FAULT = 2'd2
  } ha_sb_state_e;

  function automatic ha_result_t ha_expect(input logic a, input logic b);
    ha_result_t r;
    r.carry = a & b;
    r.sum   = a ^ b;
    return r;
  endfunction

endpackage

// File: rtl/ha_exp_fifo.sv
// Expected-result FIFO. Pointers carry one extra wrap bit so full and empty
// are told apart without a separate occupancy register.
module ha_exp_fifo
  import ha_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  ha_result_t               i_data,
  output ha_result_t               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  ha_result_t  r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ha_scoreboard.sv
// In-order result checker for the half adder: queues expected {carry, sum}
// on each launch, compares each returned result, keeps saturating statistics.
module ha_scoreboard
  import ha_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     drv_en,
  input  logic                     a,
  input  logic                     b,
  input  logic                     valid,
  input  logic                     sum,
  input  logic                     carry,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     mismatch,
  output logic                     underflow,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     fault,
  output ha_sb_state_e             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // drv_en and valid are single-cycle qualifiers without backpressure: every
  // cycle either is high counts as exactly one launch / one returned result.

  logic               w_full;
  logic               w_empty;
  logic [AW:0]        w_count;
  logic [AW:0]        w_next_cnt;
  ha_result_t         w_head;
  ha_result_t         w_obs;
  logic               w_pop;
  logic               w_push;
  logic               w_ovf;
  logic               w_udf;
  logic               w_match;
  ha_sb_state_e       r_state;
  ha_sb_state_e       w_state_nxt;
  logic [CNT_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               r_mismatch;
  logic               r_underflow;
  logic               r_overflow;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign w_pop   = valid && !w_empty;
  assign w_push  = drv_en && (!w_full || w_pop);
  assign w_ovf   = drv_en && w_full && !w_pop;
  assign w_udf   = valid && w_empty;
  assign w_obs   = '{carry: carry, sum: sum};
  assign w_match = (w_head == w_obs);
  assign w_next_cnt = w_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  ha_exp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (ha_expect(a, b)),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr)                        w_state_nxt = IDLE;
    else if (w_ovf || w_udf)        w_state_nxt = FAULT;
    else if (r_state == FAULT)      w_state_nxt = FAULT;
    else if (w_next_cnt == '0)      w_state_nxt = IDLE;
    else                            w_state_nxt = BUSY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pass_cnt  <= '0;
      r_err_cnt   <= '0;
      r_mismatch  <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (clr) begin
      r_pass_cnt  <= '0;
      r_err_cnt   <= '0;
      r_mismatch  <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_mismatch <= w_pop && !w_match;
      if (w_pop && w_match && (r_pass_cnt != {CNT_W{1'b1}}))
        r_pass_cnt <= r_pass_cnt + CNT_ONE;
      if (w_pop && !w_match && (r_err_cnt != {CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + CNT_ONE;
      if (w_udf) r_underflow <= 1'b1;
      if (w_ovf) r_overflow  <= 1'b1;
    end
  end

  assign pass_cnt  = r_pass_cnt;
  assign err_cnt   = r_err_cnt;
  assign mismatch  = r_mismatch;
  assign underflow = r_underflow;
  assign overflow  = r_overflow;
  assign pending   = w_count;
  assign fault     = (r_state == FAULT);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ha_scoreboard.sv
// Bench for ha_scoreboard: directed plan plus random traffic, checked every
// cycle against a queue-based reference model of the collector.
module tb_ha_scoreboard;
  import ha_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int CW2   = 2;

  typedef struct packed {
    logic [15:0] pass;
    logic [15:0] err;
    logic [1:0]  pass2;
    logic [1:0]  err2;
    logic        mis;
    logic        udf;
    logic        ovf;
    logic [2:0]  pend;
    logic        flt;
    logic [1:0]  st;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0, drv_en = 1'b0, a = 1'b0, b = 1'b0;
  logic valid = 1'b0, sum = 1'b0, carry = 1'b0;

  logic [CW-1:0]  pass_cnt, err_cnt;
  logic           mismatch, underflow, overflow, fault;
  logic [2:0]     pending;
  ha_sb_state_e   dbg_state;

  logic [CW2-1:0] pass_cnt2, err_cnt2;
  logic           mismatch2, underflow2, overflow2, fault2;
  logic [2:0]     pending2;
  ha_sb_state_e   dbg_state2;

  always #5 clk = ~clk;

  ha_scoreboard #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .clr(clr), .drv_en(drv_en), .a(a), .b(b),
    .valid(valid), .sum(sum), .carry(carry),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt), .mismatch(mismatch),
    .underflow(underflow), .overflow(overflow), .pending(pending),
    .fault(fault), .dbg_state(dbg_state)
  );

  ha_scoreboard #(.DEPTH(DEPTH), .CNT_W(CW2)) dut_sat (
    .clk(clk), .reset(reset), .clr(clr), .drv_en(drv_en), .a(a), .b(b),
    .valid(valid), .sum(sum), .carry(carry),
    .pass_cnt(pass_cnt2), .err_cnt(err_cnt2), .mismatch(mismatch2),
    .underflow(underflow2), .overflow(overflow2), .pending(pending2),
    .fault(fault2), .dbg_state(dbg_state2)
  );

  // ---------------- reference model ----------------
  logic [1:0] mq[$];
  int m_pass = 0, m_err = 0;
  bit m_mis = 0, m_udf = 0, m_ovf = 0, m_flt = 0;
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // Outputs the collector should show after the edge that sampled the inputs.
  task automatic model_step();
    logic [1:0] e;
    logic [1:0] s;
    exp_t x;
    if (!reset || clr) begin
      mq.delete();
      m_pass = 0; m_err = 0;
      m_mis = 0; m_udf = 0; m_ovf = 0; m_flt = 0;
    end else begin
      m_mis = 0;
      if (valid) begin
        if (mq.size() == 0) begin
          m_udf = 1; m_flt = 1;
        end else begin
          e = mq.pop_front();
          if (e == {carry, sum}) m_pass++;
          else begin m_err++; m_mis = 1; end
        end
      end
      if (drv_en) begin
        if (mq.size() == DEPTH) begin
          m_ovf = 1; m_flt = 1;
        end else begin
          s = 2'(a) + 2'(b);
          mq.push_back(s);
        end
      end
    end
    x.pass  = 16'(sat(m_pass, CW));
    x.err   = 16'(sat(m_err, CW));
    x.pass2 = 2'(sat(m_pass, CW2));
    x.err2  = 2'(sat(m_err, CW2));
    x.mis   = m_mis;
    x.udf   = m_udf;
    x.ovf   = m_ovf;
    x.pend  = 3'(mq.size());
    x.flt   = m_flt;
    x.st    = m_flt ? FAULT : ((mq.size() == 0) ? IDLE : BUSY);
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pass_cnt",   32'(pass_cnt),   32'(e.pass));
      chk("err_cnt",    32'(err_cnt),    32'(e.err));
      chk("mismatch",   32'(mismatch),   32'(e.mis));
      chk("underflow",  32'(underflow),  32'(e.udf));
      chk("overflow",   32'(overflow),   32'(e.ovf));
      chk("pending",    32'(pending),    32'(e.pend));
      chk("fault",      32'(fault),      32'(e.flt));
      chk("state",      32'(dbg_state),  32'(e.st));
      chk("pass_cnt2",  32'(pass_cnt2),  32'(e.pass2));
      chk("err_cnt2",   32'(err_cnt2),   32'(e.err2));
      chk("mismatch2",  32'(mismatch2),  32'(e.mis));
      chk("underflow2", 32'(underflow2), 32'(e.udf));
      chk("overflow2",  32'(overflow2),  32'(e.ovf));
      chk("pending2",   32'(pending2),   32'(e.pend));
      chk("fault2",     32'(fault2),     32'(e.flt));
      chk("state2",     32'(dbg_state2), 32'(e.st));
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input bit rst_v, input bit clr_v, input bit drv_v,
                       input bit a_v, input bit b_v, input bit val_v,
                       input bit c_v, input bit s_v);
    @(negedge clk);
    #1;
    reset = rst_v; clr = clr_v; drv_en = drv_v; a = a_v; b = b_v;
    valid = val_v; carry = c_v; sum = s_v;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input bit a_v, input bit b_v);
    cycle(1, 0, 1, a_v, b_v, 0, 0, 0);
  endtask

  task automatic ret(input bit c_v, input bit s_v);
    cycle(1, 0, 0, 0, 0, 1, c_v, s_v);
  endtask

  initial begin
    bit dv, vv, cr, rr, av, bv;
    logic [1:0] res;

    // reset for two cycles, then release
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("rst_pass", 32'(pass_cnt), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_fault", 32'(fault), 0);

    // four correct results, each one cycle behind its launch
    push(0, 0);
    cycle(1, 0, 1, 0, 1, 1, 0, 0);
    cycle(1, 0, 1, 1, 0, 1, 0, 1);
    cycle(1, 0, 1, 1, 1, 1, 0, 1);
    ret(1, 0);
    chk("seq_pass", 32'(pass_cnt), 4);
    chk("seq_err", 32'(err_cnt), 0);
    chk("seq_pend", 32'(pending), 0);
    chk("seq_state", 32'(dbg_state), 32'(IDLE));

    // single wrong result
    push(1, 1);
    ret(0, 1);
    chk("mis_pulse", 32'(mismatch), 1);
    chk("mis_err", 32'(err_cnt), 1);
    idle();
    chk("mis_drop", 32'(mismatch), 0);
    chk("mis_pass", 32'(pass_cnt), 4);

    // overflow, push+pop while full, then clear
    for (int i = 0; i < 5; i++) push(1, 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_pend", 32'(pending), 4);
    cycle(1, 0, 1, 1, 1, 1, 1, 0);
    chk("full_pp_pend", 32'(pending), 4);
    chk("full_pp_err", 32'(err_cnt), 1);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    chk("clr_pass", 32'(pass_cnt), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_fault", 32'(fault), 0);

    // underflow with a simultaneous launch into an empty FIFO
    cycle(1, 0, 1, 0, 1, 1, 0, 1);
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_pend", 32'(pending), 1);
    chk("udf_pass", 32'(pass_cnt), 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);

    // counter saturation on the narrow instance
    for (int i = 0; i < 5; i++) begin
      push(0, 0);
      ret(1, 1);
    end
    chk("sat_err2", 32'(err_cnt2), 3);
    chk("sat_err", 32'(err_cnt), 5);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);

    // reset mid-stream discards outstanding entries
    push(1, 0);
    push(0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    ret(0, 1);
    chk("rst_mid_udf", 32'(underflow), 1);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      dv  = ($urandom_range(0, 99) < 45);
      vv  = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      res = (mq.size() > 0 && $urandom_range(0, 99) < 85) ? mq[0] : 2'($urandom_range(0, 3));
      cr  = ($urandom_range(0, 24) == 0);
      rr  = ($urandom_range(0, 99) == 0);
      av  = ($urandom_range(0, 1) == 1);
      bv  = ($urandom_range(0, 1) == 1);
      cycle(!rr, cr, dv, av, bv, vv, res[1], res[0]);
    end

    idle();
    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
